// File: rtl/sort_frame_serializer.sv
// sort_frame_serializer: buffers whole sorted frames and streams them out one byte per beat.
// Optional lane-order checker is enabled with `define SORT_CHECK_EN.
module sort_frame_serializer #(
    parameter int LANES = 32,
    parameter int DW    = 8,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         frm_vld,
    input  logic [LANES*DW-1:0]          frm_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [DW-1:0]                m_data,
    output logic [$clog2(LANES)-1:0]     m_idx,
    output logic                         m_first,
    output logic                         m_last,
    output logic [$clog2(DEPTH):0]       occ,
    output logic                         ovf,
    output logic                         ord_err
);
    localparam int IW = $clog2(LANES);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = $clog2(DEPTH) + 1;

    logic [LANES-1:0][DW-1:0] buf_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OW-1:0] occ_q, occ_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          ovf_q, ovf_d, valid_q, valid_d;
    logic          hs, pop, wr_en;

    // A frame may enter a full buffer only when the head frame leaves in the same cycle.
    always_comb begin
        hs       = valid_q & m_ready;
        pop      = hs & (idx_q == IW'(LANES - 1));
        wr_en    = frm_vld & ((occ_q != OW'(DEPTH)) | pop);
        wr_ptr_d = wr_en ? ((wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
        rd_ptr_d = pop ? ((rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
        idx_d    = pop ? '0 : hs ? idx_q + 1'b1 : idx_q;
        occ_d    = (wr_en & ~pop) ? occ_q + 1'b1 : (pop & ~wr_en) ? occ_q - 1'b1 : occ_q;
        valid_d  = occ_d != '0;
        ovf_d    = ovf_q | (frm_vld & ~wr_en);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            idx_q    <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            idx_q    <= idx_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) buf_q[wr_ptr_q] <= frm_data;
    end

    assign m_valid = valid_q;
    assign m_data  = valid_q ? buf_q[rd_ptr_q][idx_q] : '0;
    assign m_idx   = idx_q;
    assign m_first = valid_q & (idx_q == '0);
    assign m_last  = valid_q & (idx_q == IW'(LANES - 1));
    assign occ     = occ_q;
    assign ovf     = ovf_q;

`ifdef SORT_CHECK_EN
    logic [LANES-1:0][DW-1:0] lanes;
    logic                     unsorted, ord_err_q, ord_err_d;

    // Only frames that actually enter the buffer are checked.
    always_comb begin
        lanes    = frm_data;
        unsorted = 1'b0;
        for (int i = 0; i < LANES - 1; i++) unsorted = unsorted | (lanes[i] > lanes[i+1]);
        ord_err_d = ord_err_q | (wr_en & unsorted);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ord_err_q <= 1'b0;
        else     ord_err_q <= ord_err_d;
    end

    assign ord_err = ord_err_q;
`else
    assign ord_err = 1'b0;
`endif
endmodule

// File: tb/tb_sort_frame_serializer.sv
// tb_sort_frame_serializer: directed self-checking bench for sort_frame_serializer.
module tb_sort_frame_serializer;
    localparam int LANES = 32, DW = 8, DEPTH = 2;

    logic                clk = 1'b0, rst = 1'b1, frm_vld = 1'b0, m_ready = 1'b0;
    logic [LANES*DW-1:0] frm_data = '0;
    logic                m_valid, m_first, m_last, ovf, ord_err;
    logic [DW-1:0]       m_data;
    logic [4:0]          m_idx;
    logic [1:0]          occ;
    int                  checks = 0, errors = 0;

    always #5 clk = ~clk;

    sort_frame_serializer #(.LANES(LANES), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .frm_vld(frm_vld), .frm_data(frm_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_idx(m_idx),
        .m_first(m_first), .m_last(m_last), .occ(occ), .ovf(ovf), .ord_err(ord_err)
    );

    function automatic logic [LANES*DW-1:0] fill(input logic [DW-1:0] b);
        logic [LANES*DW-1:0] f;
        for (int i = 0; i < LANES; i++) f[i*DW +: DW] = b;
        return f;
    endfunction

    function automatic logic [LANES*DW-1:0] ramp();
        logic [LANES*DW-1:0] f;
        for (int i = 0; i < LANES; i++) f[i*DW +: DW] = DW'(2 * i);
        return f;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; frm_vld = 1'b0; m_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({m_valid, m_data, m_idx, m_first, m_last, occ, ovf, ord_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b d=%h i=%0d f=%b l=%b occ=%0d ovf=%b oe=%b, need all 0",
                     m_valid, m_data, m_idx, m_first, m_last, occ, ovf, ord_err);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({m_valid, occ} !== '0) begin
            errors++; $display("FAIL idle_after_reset: got v=%b occ=%0d, need 0 0", m_valid, occ);
        end
    endtask

    task automatic test_single_frame();
        do_reset();
        @(negedge clk);
        frm_data = ramp(); frm_vld = 1'b1; m_ready = 1'b1;
        checks++;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL single_no_comb_path: m_valid=%b need 0", m_valid); end
        @(negedge clk);
        frm_vld = 1'b0;
        checks++;
        if (occ !== 2'd1) begin errors++; $display("FAIL single_occ1: occ=%0d need 1", occ); end
        for (int i = 0; i < LANES; i++) begin
            checks++;
            if ({m_valid, m_first, m_last, m_idx, m_data} !== {1'b1, i == 0, i == 31, 5'(i), 8'(2 * i)}) begin
                errors++;
                $display("FAIL single_beat%0d: v=%b f=%b l=%b idx=%0d d=%h need idx=%0d d=%h",
                         i, m_valid, m_first, m_last, m_idx, m_data, i, 8'(2 * i));
            end
            @(negedge clk);
        end
        checks++;
        if ({m_valid, occ, m_data} !== '0) begin
            errors++; $display("FAIL single_drained: v=%b occ=%0d d=%h need 0", m_valid, occ, m_data);
        end
        checks++;
        if (ord_err !== 1'b0) begin errors++; $display("FAIL single_sorted_ord_err: got %b need 0", ord_err); end
    endtask

    task automatic test_stall_toggle();
        int            cnt = 0;
        logic          stalled = 1'b0;
        logic [DW-1:0] pd = '0;
        logic [4:0]    pi = '0;
        do_reset();
        @(negedge clk);
        frm_data = ramp(); frm_vld = 1'b1;
        @(negedge clk);
        frm_vld = 1'b0;
        for (int g = 0; g < 200 && cnt < LANES; g++) begin
            if (stalled) begin
                checks++;
                if ({m_data, m_idx} !== {pd, pi}) begin
                    errors++; $display("FAIL stall_hold: d=%h idx=%0d need d=%h idx=%0d", m_data, m_idx, pd, pi);
                end
            end
            m_ready = ~m_ready;
            stalled = 1'b0;
            if (m_valid && m_ready) begin
                checks++;
                if ({m_idx, m_data} !== {5'(cnt), 8'(2 * cnt)}) begin
                    errors++; $display("FAIL stall_beat%0d: idx=%0d d=%h need idx=%0d d=%h", cnt, m_idx, m_data, cnt, 8'(2 * cnt));
                end
                cnt++;
            end else if (m_valid) begin
                stalled = 1'b1; pd = m_data; pi = m_idx;
            end
            @(negedge clk);
        end
        checks++;
        if (cnt !== LANES) begin errors++; $display("FAIL stall_count: got %0d beats need %0d", cnt, LANES); end
        checks++;
        if ({m_valid, occ} !== '0) begin errors++; $display("FAIL stall_drained: v=%b occ=%0d need 0", m_valid, occ); end
        m_ready = 1'b0;
    endtask

    task automatic test_overflow();
        logic [DW-1:0] e;
        do_reset();
        @(negedge clk); frm_data = fill(8'h11); frm_vld = 1'b1;
        @(negedge clk); frm_data = fill(8'h22);
        @(negedge clk); frm_data = fill(8'h33);
        @(negedge clk); frm_vld = 1'b0;
        checks++;
        if ({occ, ovf} !== {2'd2, 1'b1}) begin errors++; $display("FAIL ovf_state: occ=%0d ovf=%b need 2 1", occ, ovf); end
        m_ready = 1'b1;
        for (int i = 0; i < 2 * LANES; i++) begin
            e = (i < LANES) ? 8'h11 : 8'h22;
            checks++;
            if ({m_valid, m_idx, m_data} !== {1'b1, 5'(i % LANES), e}) begin
                errors++; $display("FAIL ovf_beat%0d: v=%b idx=%0d d=%h need idx=%0d d=%h", i, m_valid, m_idx, m_data, i % LANES, e);
            end
            @(negedge clk);
        end
        checks++;
        if ({m_valid, occ, ovf} !== {1'b0, 2'd0, 1'b1}) begin
            errors++; $display("FAIL ovf_after: v=%b occ=%0d ovf=%b need 0 0 1", m_valid, occ, ovf);
        end
    endtask

    task automatic test_full_simultaneous();
        logic [DW-1:0] e;
        do_reset();
        @(negedge clk); frm_data = fill(8'h11); frm_vld = 1'b1;
        @(negedge clk); frm_data = fill(8'h22);
        @(negedge clk); frm_vld = 1'b0;
        checks++;
        if (occ !== 2'd2) begin errors++; $display("FAIL full_occ: occ=%0d need 2", occ); end
        m_ready = 1'b1;
        for (int i = 0; i < LANES; i++) begin
            checks++;
            if ({m_valid, m_idx, m_data} !== {1'b1, 5'(i), 8'h11}) begin
                errors++; $display("FAIL full_a_beat%0d: v=%b idx=%0d d=%h need d=11", i, m_valid, m_idx, m_data);
            end
            if (i == LANES - 1) begin frm_data = fill(8'h44); frm_vld = 1'b1; end
            @(negedge clk);
            frm_vld = 1'b0;
        end
        checks++;
        if ({occ, ovf} !== {2'd2, 1'b0}) begin errors++; $display("FAIL full_simul: occ=%0d ovf=%b need 2 0", occ, ovf); end
        for (int i = 0; i < 2 * LANES; i++) begin
            e = (i < LANES) ? 8'h22 : 8'h44;
            checks++;
            if ({m_valid, m_idx, m_data} !== {1'b1, 5'(i % LANES), e}) begin
                errors++; $display("FAIL full_bc_beat%0d: v=%b idx=%0d d=%h need idx=%0d d=%h", i, m_valid, m_idx, m_data, i % LANES, e);
            end
            @(negedge clk);
        end
        checks++;
        if ({m_valid, occ, ovf} !== '0) begin errors++; $display("FAIL full_after: v=%b occ=%0d ovf=%b need 0", m_valid, occ, ovf); end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        m_ready = 1'b1;
        @(negedge clk); frm_data = fill(8'h55); frm_vld = 1'b1;
        @(negedge clk); frm_vld = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if ({m_valid, m_idx} !== {1'b1, 5'd10}) begin errors++; $display("FAIL mid_idx: v=%b idx=%0d need 1 10", m_valid, m_idx); end
        rst = 1'b1;
        #1;
        checks++;
        if ({m_valid, occ, m_idx, m_data, m_first, m_last} !== '0) begin
            errors++; $display("FAIL mid_reset_now: v=%b occ=%0d idx=%0d d=%h need 0", m_valid, occ, m_idx, m_data);
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk); frm_data = fill(8'hAB); frm_vld = 1'b1;
        @(negedge clk); frm_vld = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            checks++;
            if ({m_valid, m_first, m_last, m_idx, m_data} !== {1'b1, i == 0, i == 31, 5'(i), 8'hAB}) begin
                errors++; $display("FAIL mid_beat%0d: v=%b idx=%0d d=%h need idx=%0d d=ab", i, m_valid, m_idx, m_data, i);
            end
            @(negedge clk);
        end
        checks++;
        if ({m_valid, occ} !== '0) begin errors++; $display("FAIL mid_drained: v=%b occ=%0d need 0", m_valid, occ); end
    endtask

    task automatic test_order_check();
        logic [LANES*DW-1:0] f;
        logic                exp;
`ifdef SORT_CHECK_EN
        exp = 1'b1;
`else
        exp = 1'b0;
`endif
        for (int i = 0; i < LANES; i++) f[i*DW +: DW] = DW'(i);
        f[5*DW +: DW] = 8'd9;
        f[6*DW +: DW] = 8'd3;
        do_reset();
        m_ready = 1'b1;
        @(negedge clk); frm_data = f; frm_vld = 1'b1;
        checks++;
        if (ord_err !== 1'b0) begin errors++; $display("FAIL ord_before: got %b need 0", ord_err); end
        @(negedge clk); frm_vld = 1'b0;
        checks++;
        if (ord_err !== exp) begin errors++; $display("FAIL ord_after_capture: got %b need %b", ord_err, exp); end
        repeat (40) @(negedge clk);
        checks++;
        if ({ord_err, m_valid} !== {exp, 1'b0}) begin
            errors++; $display("FAIL ord_sticky: oe=%b v=%b need %b 0", ord_err, m_valid, exp);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_frame();
        test_stall_toggle();
        test_overflow();
        test_full_simultaneous();
        test_reset_mid_frame();
        test_order_check();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
